// File: rtl/tlk2711_axil_reg_bridge_if.sv
`default_nettype none
//============================================================================
// Module      : tlk2711_axil_reg_bridge_if
// Description : AXI4-Lite channel bundle between the PS master (through the
//               interconnect) and tlk2711_axil_reg_bridge.
//               Signals:
//                 awaddr/awvalid/awready         write address channel
//                 wdata/wstrb/wvalid/wready      write data channel
//                 bresp/bvalid/bready            write response channel
//                 araddr/arvalid/arready         read address channel
//                 rdata/rresp/rvalid/rready      read data channel
//               Modports: master (PS side), slave (bridge side).
// Revision    : 1.0 - initial release
//============================================================================
interface tlk2711_axil_reg_bridge_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/tlk2711_axil_reg_bridge.sv
`default_nettype none
//============================================================================
// Module      : tlk2711_axil_reg_bridge
// Description : AXI4-Lite slave that turns PS register accesses into the
//               single-cycle strobe register bus of the TLK2711 register
//               manager. Independent write and read FSMs, one outstanding
//               transaction per direction.
//               Ports:
//                 ps_clk, ps_rst_n      clock, asynchronous active-low reset
//                 s_axil                AXI4-Lite slave (interface, slave)
//                 o_reg_wen/waddr/wdata one-cycle register write strobe
//                 o_reg_ren/raddr       one-cycle register read strobe
//                 i_reg_rdata           read data, RD_LATENCY cycles after ren
//               Optional feature macro: TLK2711_AXIL_STRB_CHECK_EN
//                 defined   : partial-strobe writes are refused with SLVERR
//                 undefined : wstrb ignored, every write is full-word
// Revision    : 1.0 - initial release
//============================================================================
module tlk2711_axil_reg_bridge #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = 16'h00ff,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = 16'h0000,
    parameter int                    RD_LATENCY = 1
) (
    input  wire logic                  ps_clk,
    input  wire logic                  ps_rst_n,
    tlk2711_axil_reg_bridge_if.slave   s_axil,
    output logic                       o_reg_wen,
    output logic [ADDR_WIDTH-1:0]      o_reg_waddr,
    output logic [DATA_WIDTH-1:0]      o_reg_wdata,
    output logic                       o_reg_ren,
    output logic [ADDR_WIDTH-1:0]      o_reg_raddr,
    input  wire logic [DATA_WIDTH-1:0] i_reg_rdata
);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_ISSUE = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_WAIT  = 2'd2;
    localparam logic [1:0] R_RESP  = 2'd3;

    // R_WAIT runs RD_LATENCY cycles; the counter is loaded with latency-1
    localparam logic [2:0] c_LAT_LOAD = 3'(RD_LATENCY - 1);

    function automatic logic f_in_window(input logic [ADDR_WIDTH-1:0] addr);
        return (addr & ~ADDR_MASK) == ADDR_BASE;
    endfunction

    //------------------------------------------------------------------------
    // Write path
    //------------------------------------------------------------------------
    logic [1:0]            r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr_out;
    logic [DATA_WIDTH-1:0] r_wdata_out;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wr_go;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [1:0]            w_wr_resp;

    assign w_aw_hs = s_axil.awvalid && r_awready;
    assign w_w_hs  = s_axil.wvalid && r_wready;

    // A channel handshaking in the same cycle as the other one is already
    // held is used straight from the bus, so no extra cycle is spent.
    assign w_wr_go   = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_addr = r_aw_held ? r_awaddr : s_axil.awaddr;
    assign w_wr_data = r_w_held  ? r_wdata  : s_axil.wdata;

`ifdef TLK2711_AXIL_STRB_CHECK_EN
    logic r_wstrb_full;
    logic w_wr_strb_full;

    assign w_wr_strb_full = r_w_held ? r_wstrb_full : (&s_axil.wstrb);

    // Decode error outranks the strobe error
    always_comb begin
        w_wr_resp = c_RESP_OKAY;
        if (!f_in_window(w_wr_addr)) begin
            w_wr_resp = c_RESP_DECERR;
        end else if (!w_wr_strb_full) begin
            w_wr_resp = c_RESP_SLVERR;
        end
    end

    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) begin
            r_wstrb_full <= 1'b0;
        end else if (r_wstate == W_IDLE && w_w_hs && !w_wr_go) begin
            r_wstrb_full <= &s_axil.wstrb;
        end
    end
`else
    always_comb begin
        w_wr_resp = c_RESP_OKAY;
        if (!f_in_window(w_wr_addr)) begin
            w_wr_resp = c_RESP_DECERR;
        end
    end
`endif

    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_bvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            r_wen       <= 1'b0;
            r_waddr_out <= '0;
            r_wdata_out <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_go) begin
                        r_wstate  <= W_ISSUE;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bresp   <= w_wr_resp;
                        r_wen     <= (w_wr_resp == c_RESP_OKAY);
                        // Strobe outputs only move on an issued write
                        if (w_wr_resp == c_RESP_OKAY) begin
                            r_waddr_out <= w_wr_addr;
                            r_wdata_out <= w_wr_data;
                        end
                    end else begin
                        if (w_aw_hs) begin
                            r_awaddr  <= s_axil.awaddr;
                            r_aw_held <= 1'b1;
                            r_awready <= 1'b0;
                        end else if (!r_aw_held) begin
                            r_awready <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wdata  <= s_axil.wdata;
                            r_w_held <= 1'b1;
                            r_wready <= 1'b0;
                        end else if (!r_w_held) begin
                            r_wready <= 1'b1;
                        end
                    end
                end
                W_ISSUE: begin
                    r_wen    <= 1'b0;
                    r_bvalid <= 1'b1;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Read path
    //------------------------------------------------------------------------
    logic [1:0]            r_rstate;
    logic                  r_arready;
    logic                  r_rd_in_win;
    logic [2:0]            r_lat_cnt;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ren;
    logic [ADDR_WIDTH-1:0] r_raddr_out;

    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) begin
            r_rstate    <= R_IDLE;
            r_arready   <= 1'b0;
            r_rd_in_win <= 1'b0;
            r_lat_cnt   <= 3'd0;
            r_rvalid    <= 1'b0;
            r_rresp     <= 2'b00;
            r_rdata     <= '0;
            r_ren       <= 1'b0;
            r_raddr_out <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axil.arvalid && r_arready) begin
                        r_arready   <= 1'b0;
                        r_rd_in_win <= f_in_window(s_axil.araddr);
                        r_ren       <= f_in_window(s_axil.araddr);
                        if (f_in_window(s_axil.araddr)) begin
                            r_raddr_out <= s_axil.araddr;
                        end
                        r_rstate <= R_ISSUE;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_ISSUE: begin
                    r_ren <= 1'b0;
                    if (r_rd_in_win) begin
                        r_lat_cnt <= c_LAT_LOAD;
                        r_rstate  <= R_WAIT;
                    end else begin
                        r_rdata  <= '0;
                        r_rresp  <= c_RESP_DECERR;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_RESP;
                    end
                end
                R_WAIT: begin
                    if (r_lat_cnt == 3'd0) begin
                        r_rdata  <= i_reg_rdata;
                        r_rresp  <= c_RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                R_RESP: begin
                    if (s_axil.rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign s_axil.awready = r_awready;
    assign s_axil.wready  = r_wready;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.arready = r_arready;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rresp   = r_rresp;
    assign s_axil.rdata   = r_rdata;

    assign o_reg_wen   = r_wen;
    assign o_reg_waddr = r_waddr_out;
    assign o_reg_wdata = r_wdata_out;
    assign o_reg_ren   = r_ren;
    assign o_reg_raddr = r_raddr_out;

endmodule
`default_nettype wire
